// File: rtl/uart_fifo_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_core
// Description : Full-duplex UART with 16x-oversampled RX, RX FIFO and
//               ready/valid handshakes. Optional parity via UART_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_core #(
    parameter int CLK_DIV    = 27,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic                          tx,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic                          rx_valid,
    output logic [DATA_BITS-1:0]          rx_data,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_error,
    output logic                          parity_error,
    output logic                          rx_overrun
);

    localparam int DIV_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(FIFO_DEPTH);
    localparam logic              STOP_LAST = (STOP_BITS == 2);
`ifdef UART_PARITY_EN
    localparam logic              PAR_ODD   = (PARITY_ODD != 0);
`endif

    generate
        if (CLK_DIV < 2 || OVERSAMPLE < 8 || OVERSAMPLE > 16 || (OVERSAMPLE % 2) != 0 ||
            DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
            FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
            PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
            $error("uart_fifo_core: illegal parameter value");
        end
    endgenerate

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE
    } rx_state_t;
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    // ---------------------------------------------------------------- receiver
    logic                 rx_meta, rx_sync;
    rx_state_t            rx_state, rx_state_nx;
    logic [DIV_W-1:0]     rx_div;
    logic [TICK_W-1:0]    rx_tcnt;
    logic [BIT_W-1:0]     rx_bcnt;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_tick, rx_sample;
    logic                 rx_push, rx_stop_bad, rx_par_flag;
`ifdef UART_PARITY_EN
    logic                 rx_par_bad;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    assign rx_tick   = (rx_div == DIV_LAST);
    assign rx_sample = rx_tick && (rx_tcnt == ((rx_state == RX_START) ? TICK_MID : TICK_LAST));

    always_comb begin
        rx_state_nx = rx_state;
        rx_push     = 1'b0;
        rx_stop_bad = 1'b0;
        rx_par_flag = 1'b0;
        case (rx_state)
            RX_IDLE:      if (!rx_sync) rx_state_nx = RX_START;
            RX_START:     if (rx_sample) rx_state_nx = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (rx_sample && rx_bcnt == BIT_LAST) begin
`ifdef UART_PARITY_EN
                    rx_state_nx = RX_PARITY;
`else
                    rx_state_nx = RX_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY:    if (rx_sample) rx_state_nx = RX_STOP;
`endif
            RX_STOP: begin
                if (rx_sample) begin
                    rx_stop_bad = !rx_sync;
`ifdef UART_PARITY_EN
                    rx_par_flag = rx_par_bad;
                    rx_push     = rx_sync && !rx_par_bad;
`else
                    rx_push     = rx_sync;
`endif
                    rx_state_nx = rx_sync ? RX_IDLE : RX_WAIT_IDLE;
                end
            end
            RX_WAIT_IDLE: if (rx_sync) rx_state_nx = RX_IDLE;
            default:      rx_state_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_state_nx;
    end

    // Counters are held at zero in IDLE so each start edge re-phases sampling.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_div   <= '0;
            rx_tcnt  <= '0;
            rx_bcnt  <= '0;
            rx_shift <= '0;
        end else if (rx_state == RX_IDLE) begin
            rx_div  <= '0;
            rx_tcnt <= '0;
            rx_bcnt <= '0;
        end else begin
            rx_div <= rx_tick ? '0 : rx_div + 1'b1;
            if (rx_tick) rx_tcnt <= rx_sample ? '0 : rx_tcnt + 1'b1;
            if (rx_sample && rx_state == RX_DATA) begin
                rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                rx_bcnt  <= rx_bcnt + 1'b1;
            end
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst || rx_state == RX_IDLE)
            rx_par_bad <= 1'b0;
        else if (rx_sample && rx_state == RX_PARITY)
            rx_par_bad <= rx_sync ^ (^rx_shift) ^ PAR_ODD;
    end
    always_ff @(posedge clk) begin
        if (rst) parity_error <= 1'b0;
        else     parity_error <= rx_par_flag;
    end
`else
    assign parity_error = 1'b0;
`endif

    // -------------------------------------------------------------------- FIFO
    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]    wr_ptr, rd_ptr;
    logic                 fifo_full, fifo_pop, fifo_wr, fifo_drop;

    assign rx_valid  = (rx_count != '0);
    assign rx_data   = fifo_mem[rd_ptr];
    assign fifo_full = (rx_count == FULL_CNT);
    assign fifo_pop  = rx_valid && rx_ready;
    assign fifo_wr   = rx_push && (!fifo_full || fifo_pop);
    assign fifo_drop = rx_push && fifo_full && !fifo_pop;

    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= rx_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
        end else begin
            if (fifo_wr)  wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_wr, fifo_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_error <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            frame_error <= rx_stop_bad;
            rx_overrun  <= fifo_drop;
        end
    end

    // ------------------------------------------------------------- transmitter
    tx_state_t            tx_state, tx_state_nx;
    logic [DIV_W-1:0]     tx_div;
    logic [TICK_W-1:0]    tx_tcnt;
    logic [BIT_W-1:0]     tx_bcnt;
    logic                 tx_scnt;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_tick, tx_bit_end, tx_accept;
`ifdef UART_PARITY_EN
    logic                 tx_par;
`endif

    assign tx_ready   = (tx_state == TX_IDLE);
    assign tx_accept  = tx_valid && tx_ready;
    assign tx_tick    = (tx_div == DIV_LAST);
    assign tx_bit_end = tx_tick && (tx_tcnt == TICK_LAST);

    always_comb begin
        tx_state_nx = tx_state;
        case (tx_state)
            TX_IDLE:   if (tx_valid) tx_state_nx = TX_START;
            TX_START:  if (tx_bit_end) tx_state_nx = TX_DATA;
            TX_DATA: begin
                if (tx_bit_end && tx_bcnt == BIT_LAST) begin
`ifdef UART_PARITY_EN
                    tx_state_nx = TX_PARITY;
`else
                    tx_state_nx = TX_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: if (tx_bit_end) tx_state_nx = TX_STOP;
`endif
            TX_STOP:   if (tx_bit_end && tx_scnt == STOP_LAST) tx_state_nx = TX_IDLE;
            default:   tx_state_nx = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_state_nx;
    end

    // tx is registered and updated at the same edge the FSM changes bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx       <= 1'b1;
            tx_div   <= '0;
            tx_tcnt  <= '0;
            tx_bcnt  <= '0;
            tx_scnt  <= 1'b0;
            tx_shift <= '0;
        end else if (tx_state == TX_IDLE) begin
            tx_div  <= '0;
            tx_tcnt <= '0;
            tx_bcnt <= '0;
            tx_scnt <= 1'b0;
            if (tx_accept) begin
                tx_shift <= tx_data;
                tx       <= 1'b0;
            end
        end else begin
            tx_div <= tx_tick ? '0 : tx_div + 1'b1;
            if (tx_tick) tx_tcnt <= tx_bit_end ? '0 : tx_tcnt + 1'b1;
            if (tx_bit_end) begin
                case (tx_state)
                    TX_START: tx <= tx_shift[0];
                    TX_DATA: begin
                        tx_shift <= tx_shift >> 1;
                        tx_bcnt  <= tx_bcnt + 1'b1;
                        if (tx_bcnt == BIT_LAST) begin
`ifdef UART_PARITY_EN
                            tx <= tx_par;
`else
                            tx <= 1'b1;
`endif
                        end else begin
                            tx <= tx_shift[1];
                        end
                    end
                    TX_STOP: begin
                        tx_scnt <= tx_scnt + 1'b1;
                        tx      <= 1'b1;
                    end
                    default: tx <= 1'b1;
                endcase
            end
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)            tx_par <= 1'b0;
        else if (tx_accept) tx_par <= (^tx_data) ^ PAR_ODD;
    end
`endif

endmodule
`default_nettype wire
